// File: rtl/retro_pinmux_pkg.sv
// retro_pinmux_pkg: shared constants and types for the runtime pad multiplexer.
//   - Register byte offsets of the native-bus register map
//   - Function index of the built-in GPIO and the idle level fed to unselected inputs
//   - Per-pad state encoding and gap counter width
package retro_pinmux_pkg;

    localparam logic [7:0] PINMUX_SEL_BASE = 8'h00;
    localparam logic [7:0] PINMUX_GPIO_OUT = 8'h40;
    localparam logic [7:0] PINMUX_GPIO_OE  = 8'h44;
    localparam logic [7:0] PINMUX_GPIO_IN  = 8'h48;
    localparam logic [7:0] PINMUX_LOCK     = 8'h4C;

    localparam int unsigned FUNC_GPIO      = 0;
    // UART/I2C/SPI receivers idle high, so a disconnected input reads 1.
    localparam logic        PINMUX_IDLE_IN = 1'b1;

    localparam int unsigned GAP_CNT_W      = 4;

    typedef enum logic {
        PAD_ACTIVE = 1'b0,
        PAD_GAP    = 1'b1
    } pad_state_e;

endpackage

// File: rtl/retro_pinmux_pad.sv
// retro_pinmux_pad: one pad slice of the multiplexer.
//   Holds the function select, the forced-idle gap FSM and the input
//   synchroniser, and routes output/enable and synchronised input.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   sel_we/sel_wdata select write request (already lock-gated and clamped)
//   gpio_out/oe      built-in GPIO drive for this pad (function 0)
//   fn_out/fn_oe     per-function output and enable for this pad
//   fn_in            per-function synchronised input (idle level if unselected)
//   pad_in           raw pad input
//   pad_out/pad_oe   pad drive
//   sel              current committed select (for read-back)
//   sync_in          synchronised pad input (for GPIO_IN)
module retro_pinmux_pad
    import retro_pinmux_pkg::*;
#(
    parameter int NUM_FUNCS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SWITCH_GAP  = 4,
    parameter int FW          = $clog2(NUM_FUNCS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_we,
    input  logic [FW-1:0]        sel_wdata,
    input  logic                 gpio_out,
    input  logic                 gpio_oe,
    input  logic [NUM_FUNCS-1:0] fn_out,
    input  logic [NUM_FUNCS-1:0] fn_oe,
    output logic [NUM_FUNCS-1:0] fn_in,
    input  logic                 pad_in,
    output logic                 pad_out,
    output logic                 pad_oe,
    output logic [FW-1:0]        sel,
    output logic                 sync_in
);

    pad_state_e             state_q, state_d;
    logic [GAP_CNT_W-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]          sel_q, sel_d;
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PAD_ACTIVE;
            cnt_q   <= '0;
            sel_q   <= FW'(FUNC_GPIO);
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_in};
        end
    end

    // A differing select always (re)starts the gap, even mid-gap. The counter
    // leaves GAP on the edge where it would reach zero, so the pad is idle for
    // exactly SWITCH_GAP cycles after the committing edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (sel_we && (sel_wdata != sel_q)) begin
            sel_d   = sel_wdata;
            cnt_d   = GAP_CNT_W'(SWITCH_GAP);
            state_d = PAD_GAP;
        end else if (state_q == PAD_GAP) begin
            if (cnt_q <= GAP_CNT_W'(1)) begin
                cnt_d   = '0;
                state_d = PAD_ACTIVE;
            end else begin
                cnt_d = cnt_q - GAP_CNT_W'(1);
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign sel     = sel_q;

    always_comb begin
        pad_out = 1'b0;
        pad_oe  = 1'b0;
        for (int f = 0; f < NUM_FUNCS; f++) fn_in[f] = PINMUX_IDLE_IN;
        if (state_q == PAD_ACTIVE) begin
            if (sel_q == FW'(FUNC_GPIO)) begin
                pad_out = gpio_out;
                pad_oe  = gpio_oe;
            end else begin
                pad_out = fn_out[sel_q];
                pad_oe  = fn_oe[sel_q];
            end
            fn_in[sel_q] = sync_in;
        end
    end

endmodule

// File: rtl/retro_pinmux.sv
// retro_pinmux: runtime-configurable pad multiplexer.
//   Bus register file (PAD_SEL, GPIO_OUT/OE/IN, LOCK) plus NUM_PADS pad slices.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   reg_valid_i/ready_o     bus handshake, ready is a one-cycle pulse
//   reg_addr_i/wdata_i/wstrb_i/rdata_o  bus address, write data, strobes (0 = read), read data
//   fn_out_i/fn_oe_i/fn_in_o  function-side signals, bit f*NUM_PADS+p
//   pad_in_i/pad_out_o/pad_oe_o  pad-side signals
module retro_pinmux
    import retro_pinmux_pkg::*;
#(
    parameter int NUM_PADS    = 8,
    parameter int NUM_FUNCS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SWITCH_GAP  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           reg_valid_i,
    output logic                           reg_ready_o,
    input  logic [7:0]                     reg_addr_i,
    input  logic [31:0]                    reg_wdata_i,
    input  logic [3:0]                     reg_wstrb_i,
    output logic [31:0]                    reg_rdata_o,
    input  logic [NUM_FUNCS*NUM_PADS-1:0]  fn_out_i,
    input  logic [NUM_FUNCS*NUM_PADS-1:0]  fn_oe_i,
    output logic [NUM_FUNCS*NUM_PADS-1:0]  fn_in_o,
    input  logic [NUM_PADS-1:0]            pad_in_i,
    output logic [NUM_PADS-1:0]            pad_out_o,
    output logic [NUM_PADS-1:0]            pad_oe_o
);

    localparam int FW = $clog2(NUM_FUNCS);

    logic [NUM_PADS-1:0] gpio_out_q, gpio_oe_q, gpio_in;
    logic                lock_q;
    logic [FW-1:0]       pad_sel [NUM_PADS];
    logic [NUM_PADS-1:0] sel_we;
    logic [FW-1:0]       sel_wdata;
    logic [31:0]         rd_data;
    logic [7:0]          word_addr;
    logic                accept, is_write;
    logic                unused_bits;

    function automatic logic [FW-1:0] clamp_sel(input logic [7:0] v);
        if (v >= 8'(NUM_FUNCS)) return '0;
        return v[FW-1:0];
    endfunction

    function automatic logic [NUM_PADS-1:0] merge_bytes(input logic [NUM_PADS-1:0] cur,
                                                        input logic [31:0] wdata,
                                                        input logic [3:0] wstrb);
        logic [NUM_PADS-1:0] res;
        for (int p = 0; p < NUM_PADS; p++) res[p] = wstrb[p/8] ? wdata[p] : cur[p];
        return res;
    endfunction

    assign word_addr   = {reg_addr_i[7:2], 2'b00};
    // Ready doubles as the busy flag: valid held through the ready cycle is not re-accepted.
    assign accept      = reg_valid_i && !reg_ready_o;
    assign is_write    = |reg_wstrb_i;
    assign sel_wdata   = clamp_sel(reg_wdata_i[7:0]);
    assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i, reg_wstrb_i};

    always_comb begin
        sel_we  = '0;
        rd_data = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (word_addr == PINMUX_SEL_BASE + 8'(4*p)) begin
                sel_we[p] = accept && is_write && reg_wstrb_i[0] && !lock_q;
                rd_data   = 32'(pad_sel[p]);
            end
        end
        if (word_addr == PINMUX_GPIO_OUT) rd_data = 32'(gpio_out_q);
        if (word_addr == PINMUX_GPIO_OE)  rd_data = 32'(gpio_oe_q);
        if (word_addr == PINMUX_GPIO_IN)  rd_data = 32'(gpio_in);
        if (word_addr == PINMUX_LOCK)     rd_data = 32'(lock_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_ready_o <= 1'b0;
            reg_rdata_o <= '0;
            gpio_out_q  <= '0;
            gpio_oe_q   <= '0;
            lock_q      <= 1'b0;
        end else begin
            reg_ready_o <= accept;
            reg_rdata_o <= (accept && !is_write) ? rd_data : '0;
            if (accept && is_write) begin
                if (word_addr == PINMUX_GPIO_OUT)
                    gpio_out_q <= merge_bytes(gpio_out_q, reg_wdata_i, reg_wstrb_i);
                if (word_addr == PINMUX_GPIO_OE)
                    gpio_oe_q <= merge_bytes(gpio_oe_q, reg_wdata_i, reg_wstrb_i);
                if (word_addr == PINMUX_LOCK && reg_wstrb_i[0] && reg_wdata_i[0])
                    lock_q <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [NUM_FUNCS-1:0] col_out, col_oe, col_in;

        for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_fn
            assign col_out[f]              = fn_out_i[f*NUM_PADS+p];
            assign col_oe[f]               = fn_oe_i[f*NUM_PADS+p];
            assign fn_in_o[f*NUM_PADS+p]   = col_in[f];
        end

        retro_pinmux_pad #(
            .NUM_FUNCS   (NUM_FUNCS),
            .SYNC_STAGES (SYNC_STAGES),
            .SWITCH_GAP  (SWITCH_GAP),
            .FW          (FW)
        ) u_pad (
            .clk       (clk_i),
            .rst       (rst_i),
            .sel_we    (sel_we[p]),
            .sel_wdata (sel_wdata),
            .gpio_out  (gpio_out_q[p]),
            .gpio_oe   (gpio_oe_q[p]),
            .fn_out    (col_out),
            .fn_oe     (col_oe),
            .fn_in     (col_in),
            .pad_in    (pad_in_i[p]),
            .pad_out   (pad_out_o[p]),
            .pad_oe    (pad_oe_o[p]),
            .sel       (pad_sel[p]),
            .sync_in   (gpio_in[p])
        );
    end

endmodule

// File: tb/tb_retro_pinmux.sv
// tb_retro_pinmux: directed and randomized checks of retro_pinmux against a
// timestamp-based reference model (select value plus "active from cycle" per pad,
// and a history of sampled pad inputs for the synchroniser).
module tb_retro_pinmux;

    localparam int NP = 8;
    localparam int NF = 4;
    localparam int SS = 2;
    localparam int SG = 4;
    localparam int HN = 8192;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reg_valid = 1'b0;
    logic              reg_ready;
    logic [7:0]        reg_addr = '0;
    logic [31:0]       reg_wdata = '0;
    logic [3:0]        reg_wstrb = '0;
    logic [31:0]       reg_rdata;
    logic [NF*NP-1:0]  fn_out = '0;
    logic [NF*NP-1:0]  fn_oe = '0;
    logic [NF*NP-1:0]  fn_in;
    logic [NP-1:0]     pad_in = '1;
    logic [NP-1:0]     pad_out;
    logic [NP-1:0]     pad_oe;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [NP-1:0] hist [HN];

    // Reference model state
    int          m_sel [NP];
    int          m_act [NP];
    logic [NP-1:0] m_gout, m_goe;
    logic        m_lock;
    int          acc_cyc;
    bit          rnd_en = 1'b0;

    retro_pinmux #(
        .NUM_PADS(NP), .NUM_FUNCS(NF), .SYNC_STAGES(SS), .SWITCH_GAP(SG)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_valid_i (reg_valid),
        .reg_ready_o (reg_ready),
        .reg_addr_i  (reg_addr),
        .reg_wdata_i (reg_wdata),
        .reg_wstrb_i (reg_wstrb),
        .reg_rdata_o (reg_rdata),
        .fn_out_i    (fn_out),
        .fn_oe_i     (fn_oe),
        .fn_in_o     (fn_in),
        .pad_in_i    (pad_in),
        .pad_out_o   (pad_out),
        .pad_oe_o    (pad_oe)
    );

    always #5 clk = ~clk;

    // Edge counter and record of the pad input value sampled at each edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < HN) hist[cyc + 1] <= pad_in;
    end

    function automatic logic [NP-1:0] sync_after(input int k);
        int idx;
        idx = k - SS + 1;
        if (idx < 1 || idx >= HN) return '1;
        return hist[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_sel[p] = 0;
            m_act[p] = 0;
        end
        m_gout  = '0;
        m_goe   = '0;
        m_lock  = 1'b0;
        acc_cyc = -10;
    endtask

    task automatic check_pads();
        logic [NP-1:0]    eo, ee, s;
        logic [NF*NP-1:0] ei;
        s  = sync_after(cyc);
        ei = '1;
        eo = '0;
        ee = '0;
        for (int p = 0; p < NP; p++) begin
            if (cyc >= m_act[p]) begin
                if (m_sel[p] == 0) begin
                    eo[p] = m_gout[p];
                    ee[p] = m_goe[p];
                end else begin
                    eo[p] = fn_out[m_sel[p]*NP + p];
                    ee[p] = fn_oe[m_sel[p]*NP + p];
                end
                ei[m_sel[p]*NP + p] = s[p];
            end
        end
        chk("pad_out", 32'(pad_out), 32'(eo));
        chk("pad_oe", 32'(pad_oe), 32'(ee));
        chk("fn_in", fn_in, ei);
        chk("ready", 32'(reg_ready), 32'(cyc == acc_cyc));
    endtask

    task automatic step();
        @(negedge clk);
        check_pads();
        if (rnd_en) begin
            fn_out = $urandom;
            fn_oe  = $urandom;
            pad_in = NP'($urandom);
        end
    endtask

    // One bus transaction, started right after a negedge.
    task automatic bus(input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd);
        logic [31:0] exp_rd;
        int          e, w, v;
        reg_valid = 1'b1;
        reg_addr  = addr;
        reg_wdata = wd;
        reg_wstrb = ws;
        @(posedge clk);
        #1;
        e = cyc;
        w = int'(addr[7:2]);
        exp_rd = '0;
        if (w < NP)       exp_rd = 32'(m_sel[w]);
        else if (w == 16) exp_rd = 32'(m_gout);
        else if (w == 17) exp_rd = 32'(m_goe);
        else if (w == 18) exp_rd = 32'(sync_after(e - 1));
        else if (w == 19) exp_rd = 32'(m_lock);
        if (ws != 4'd0) begin
            if (w < NP && ws[0] && !m_lock) begin
                v = int'(wd[7:0]);
                if (v >= NF) v = 0;
                if (v != m_sel[w]) begin
                    m_sel[w] = v;
                    m_act[w] = e + SG;
                end
            end
            if (w == 16 && ws[0]) m_gout = wd[NP-1:0];
            if (w == 17 && ws[0]) m_goe  = wd[NP-1:0];
            if (w == 19 && ws[0] && wd[0]) m_lock = 1'b1;
        end
        acc_cyc = e;
        step();
        rd = reg_rdata;
        if (ws == 4'd0) chk("rdata", reg_rdata, exp_rd);
        reg_valid = 1'b0;
        reg_wstrb = '0;
        step();
    endtask

    initial begin
        logic [31:0] rd;
        int          pick;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          e1;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        step();
        chk("rst_pad_oe", 32'(pad_oe), 32'h0);
        chk("rst_pad_out", 32'(pad_out), 32'h0);
        chk("rst_fn_in", fn_in, 32'hFFFF_FFFF);
        pad_in = 8'h3C;
        repeat (3) step();
        bus(8'h48, 32'h0, 4'h0, rd);
        chk("gpio_in", rd, 32'h3C);

        // GPIO drive and read-back
        bus(8'h44, 32'hFF, 4'h1, rd);
        bus(8'h40, 32'hA5, 4'h1, rd);
        chk("gpio_pad_out", 32'(pad_out), 32'hA5);
        chk("gpio_pad_oe", 32'(pad_oe), 32'hFF);
        bus(8'h40, 32'h0, 4'h0, rd);
        chk("rb_gpio_out", rd, 32'hA5);
        bus(8'h44, 32'h0, 4'h0, rd);
        chk("rb_gpio_oe", rd, 32'hFF);

        // Function 2 on pad 3 with switch gap and input routing
        fn_out[19] = 1'b1;
        fn_oe[19]  = 1'b1;
        bus(8'h0C, 32'h2, 4'h1, rd);
        repeat (3) step();
        chk("f2_pad3_out", 32'(pad_out[3]), 32'h1);
        chk("f2_pad3_oe", 32'(pad_oe[3]), 32'h1);
        pad_in[3] = ~pad_in[3];
        repeat (2) step();
        chk("f2_fn_in19", 32'(fn_in[19]), 32'(pad_in[3]));
        chk("f2_fn_in11", 32'(fn_in[11]), 32'h1);

        // Gap restart by a second differing write, then a same-value write
        fn_out[11] = 1'b1;
        fn_oe[11]  = 1'b1;
        bus(8'h0C, 32'h0, 4'h1, rd);
        bus(8'h0C, 32'h1, 4'h1, rd);
        repeat (4) step();
        bus(8'h0C, 32'h1, 4'h1, rd);
        chk("same_val_oe", 32'(pad_oe[3]), 32'h1);

        // Out-of-range select clamps to GPIO
        bus(8'h00, 32'h3, 4'h1, rd);
        bus(8'h00, 32'h5, 4'h1, rd);
        bus(8'h00, 32'h0, 4'h0, rd);
        chk("clamp_sel", rd, 32'h0);
        repeat (4) step();

        // Randomized traffic on all registers except LOCK
        rnd_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            pick = int'($urandom_range(0, 13));
            wd   = $urandom;
            if (pick < 8) begin
                a = 8'(4 * pick);
                wd[7:0] = 8'($urandom_range(0, 7));
            end else if (pick == 8)  a = 8'h40;
            else if (pick == 9)  a = 8'h44;
            else if (pick == 10) a = 8'h48;
            else if (pick == 11) a = 8'(8'h20 + 8'(4 * $urandom_range(0, 7)));
            else if (pick == 12) a = 8'h50;
            else a = 8'(8'h80 + 8'($urandom_range(0, 31)));
            a[1:0] = 2'($urandom_range(0, 3));
            ws = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) ws = 4'h0;
            bus(a, wd, ws, rd);
            repeat ($urandom_range(0, 4)) step();
        end
        rnd_en = 1'b0;
        repeat (SG + 1) step();

        // LOCK freezes selects but not GPIO
        bus(8'h00, 32'h2, 4'h1, rd);
        repeat (SG + 1) step();
        bus(8'h4C, 32'h1, 4'h1, rd);
        bus(8'h00, 32'h3, 4'h1, rd);
        bus(8'h00, 32'h0, 4'h0, rd);
        chk("lock_sel", rd, 32'h2);
        bus(8'h4C, 32'h0, 4'h0, rd);
        chk("lock_rd", rd, 32'h1);
        bus(8'h40, 32'h5A, 4'h1, rd);
        bus(8'h40, 32'h0, 4'h0, rd);
        chk("lock_gpio", rd, 32'h5A);

        // Asynchronous reset in the middle of a gap, with GPIO driving high
        pad_in = '1;
        bus(8'h44, 32'hFF, 4'h1, rd);
        repeat (3) step();
        rst = 1'b1;
        model_reset();
        #1;
        chk("pre_gap_reset_oe", 32'(pad_oe), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        bus(8'h44, 32'hFF, 4'h1, rd);
        bus(8'h40, 32'hFF, 4'h1, rd);
        bus(8'h0C, 32'h3, 4'h1, rd);
        e1 = cyc;
        bus(8'h4C, 32'h1, 4'h1, rd);
        chk("in_gap", 32'(cyc < m_act[3]), 32'h1);
        chk("in_gap_oe3", 32'(pad_oe[3]), 32'h0);
        chk("other_pad_drive", 32'(pad_out[0]), 32'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_pad_out", 32'(pad_out), 32'h0);
        chk("async_pad_oe", 32'(pad_oe), 32'h0);
        check_pads();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        bus(8'h0C, 32'h0, 4'h0, rd);
        chk("rst_sel3", rd, 32'h0);
        bus(8'h4C, 32'h0, 4'h0, rd);
        chk("rst_lock", rd, 32'h0);
        chk("gap_started", 32'(e1 > 0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
